// File: rtl/sram_shape_loader_pkg.sv
// Shared definitions for the SRAM shape loader: FSM encoding and the
// default SRAM integration widths.
package sram_shape_loader_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    WAIT  = ST_WAIT,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } load_state_t;

  // Default SRAM integration widths
  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  // Shape register bank slot select width
  localparam int SLOT_SEL_W = 2;

endpackage

// File: rtl/sram_shape_loader.sv
// Reads NUM_WORDS consecutive words from a synchronous SRAM and writes them
// into the shape register bank, one wr_en pulse per word with sel = index.
// The downstream register bank resets active-high; the top level drives it
// from the same source as this block's reset, inverted.
module sram_shape_loader
  import sram_shape_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 2,
  parameter int NUM_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic                  sram_rd_en,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  wr_en,
  output logic [SLOT_SEL_W-1:0] sel,
  output logic [DATA_W-1:0]     data_out,
  output logic                  busy,
  output logic                  done
);

  // Last word index and the latency count at which read data is valid
  localparam logic [SLOT_SEL_W-1:0] LAST_IDX = SLOT_SEL_W'(NUM_WORDS - 1);
  localparam logic [2:0]            LAT_LAST = 3'(RD_LAT - 1);

  load_state_t             state_r;
  logic [SLOT_SEL_W-1:0]   idx_r;
  logic [2:0]              lat_cnt_r;
  logic [ADDR_W-1:0]       addr_q_r;
  logic [ADDR_W-1:0]       sram_addr_r;
  logic                    sram_rd_en_r;
  logic                    wr_en_r;
  logic [SLOT_SEL_W-1:0]   sel_r;
  logic [DATA_W-1:0]       data_out_r;
  logic                    busy_r;
  logic                    done_r;
  logic [SLOT_SEL_W-1:0]   next_idx_s;

  assign next_idx_s = idx_r + 2'd1;

  // Load sequencer: outputs are set on the edge entering each state so they
  // are registered and aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      idx_r        <= 2'd0;
      lat_cnt_r    <= 3'd0;
      addr_q_r     <= '0;
      sram_addr_r  <= '0;
      sram_rd_en_r <= 1'b0;
      wr_en_r      <= 1'b0;
      sel_r        <= 2'd0;
      data_out_r   <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            addr_q_r     <= base_addr;
            idx_r        <= 2'd0;
            sram_addr_r  <= base_addr;
            sram_rd_en_r <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= REQ;
          end
        end
        REQ: begin
          sram_rd_en_r <= 1'b0;
          lat_cnt_r    <= 3'd0;
          state_r      <= WAIT;
        end
        WAIT: begin
          lat_cnt_r <= lat_cnt_r + 3'd1;
          if (lat_cnt_r == LAT_LAST) begin
            data_out_r <= sram_rdata;
            sel_r      <= idx_r;
            wr_en_r    <= 1'b1;
            state_r    <= WRITE;
          end
        end
        WRITE: begin
          wr_en_r <= 1'b0;
          if (idx_r == LAST_IDX) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            // Address wraps modulo 2^ADDR_W by construction
            idx_r        <= next_idx_s;
            sram_addr_r  <= addr_q_r + ADDR_W'(next_idx_s);
            sram_rd_en_r <= 1'b1;
            state_r      <= REQ;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          sram_rd_en_r <= 1'b0;
          wr_en_r      <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign sram_addr  = sram_addr_r;
  assign sram_rd_en = sram_rd_en_r;
  assign wr_en      = wr_en_r;
  assign sel        = sel_r;
  assign data_out   = data_out_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_sram_shape_loader.sv
// Self-checking bench for sram_shape_loader: three instances (RD_LAT 2, 1, 4)
// share the stimulus; each has its own SRAM model and a cycle-schedule
// reference model derived from the load timing rules.
module tb_sram_shape_loader;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // SRAM contents: fixed words for the nominal test, a hash elsewhere
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      18'h00100: mem_word = 16'hA001;
      18'h00101: mem_word = 16'hB002;
      18'h00102: mem_word = 16'hC003;
      18'h00103: mem_word = 16'hD004;
      default:   mem_word = a[15:0] ^ {a[17:16], a[15:2]} ^ 16'h5C3A;
    endcase
  endfunction

  // Cycle index within a load (0 = idle); load of NW words lasts NW*per busy
  // cycles followed by one done cycle, during which start is ignored.
  function automatic int next_t(input int t, input logic st, input int per);
    if (t == 0) return st ? 1 : 0;
    if (t == NW * per + 1) return 0;
    return t + 1;
  endfunction

  function automatic bit is_wr(input int t, input int per);
    return (t >= 1) && (t <= NW * per) && (t % per == 0);
  endfunction

  function automatic bit is_rd(input int t, input int per);
    return (t >= 1) && (t <= NW * per) && ((t - 1) % per == 0);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    localparam int P   = LAT + 2;

    logic [AW-1:0] sram_addr;
    logic          sram_rd_en;
    logic [DW-1:0] sram_rdata;
    logic          wr_en;
    logic [1:0]    sel;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          done;

    sram_shape_loader #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .NUM_WORDS(NW)
    ) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .sram_addr(sram_addr), .sram_rd_en(sram_rd_en), .sram_rdata(sram_rdata),
      .wr_en(wr_en), .sel(sel), .data_out(data_out), .busy(busy), .done(done)
    );

    // SRAM model: data valid only LAT cycles after the rd_en cycle, junk otherwise
    logic          pv [LAT];
    logic [AW-1:0] pa [LAT];
    logic [DW-1:0] junk;

    always @(posedge clk) begin
      junk  <= DW'($urandom);
      pv[0] <= sram_rd_en;
      pa[0] <= sram_addr;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end

    assign sram_rdata = pv[LAT-1] ? mem_word(pa[LAT-1]) : junk;

    // Reference model: load schedule position plus held write values
    int            t_r;
    logic [AW-1:0] mbase_r;
    logic [DW-1:0] exp_data_r;
    logic [1:0]    exp_sel_r;
    logic          rst_r;

    always @(posedge clk) begin
      if (!reset) begin
        t_r        <= 0;
        exp_data_r <= '0;
        exp_sel_r  <= 2'd0;
        rst_r      <= 1'b1;
      end else begin
        rst_r <= 1'b0;
        t_r   <= next_t(t_r, start, P);
        if (t_r == 0 && start) mbase_r <= base_addr;
        if (is_wr(next_t(t_r, start, P), P)) begin
          exp_sel_r  <= 2'(next_t(t_r, start, P) / P - 1);
          exp_data_r <= mem_word(mbase_r + AW'(next_t(t_r, start, P) / P - 1));
        end
      end
    end

    // Compare all outputs mid-cycle against the schedule
    always @(negedge clk) begin
      check_val($sformatf("busy_L%0d", LAT), {31'd0, busy}, {31'd0, (t_r >= 1 && t_r <= NW * P)});
      check_val($sformatf("done_L%0d", LAT), {31'd0, done}, {31'd0, (t_r == NW * P + 1)});
      check_val($sformatf("rd_en_L%0d", LAT), {31'd0, sram_rd_en}, {31'd0, is_rd(t_r, P)});
      check_val($sformatf("wr_en_L%0d", LAT), {31'd0, wr_en}, {31'd0, is_wr(t_r, P)});
      check_val($sformatf("sel_L%0d", LAT), {30'd0, sel}, {30'd0, exp_sel_r});
      check_val($sformatf("data_L%0d", LAT), {16'd0, data_out}, {16'd0, exp_data_r});
      if (is_rd(t_r, P))
        check_val($sformatf("addr_L%0d", LAT), {14'd0, sram_addr},
                  {14'd0, mbase_r + AW'((t_r - 1) / P)});
      if (rst_r)
        check_val($sformatf("rst_addr_L%0d", LAT), {14'd0, sram_addr}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Nominal load with start re-asserted in cycles 3 and 10, base changed after acceptance
    base_addr = 18'h00100;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = 18'h2AAAA;
    for (int n = 1; n <= 30; n++) begin
      start = (n == 3 || n == 10);
      tick();
    end

    // Address wrap
    base_addr = 18'h3FFFF;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();

    // Start in the cycle after done (RD_LAT=2 instance)
    base_addr = 18'h01234;
    start     = 1'b1;
    tick();
    for (int n = 1; n <= 50; n++) begin
      start = (n == 18);
      base_addr = 18'h04000 + AW'(n);
      tick();
    end

    // Start held high: every instance restarts as soon as it is idle
    start = 1'b1;
    repeat (60) tick();
    start = 1'b0;
    repeat (30) tick();

    // Reset for 3 cycles during word 2 wait of the RD_LAT=2 load
    base_addr = 18'h00100;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (30) tick();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      start     = ($urandom_range(0, 7) == 0);
      base_addr = AW'($urandom);
      reset     = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1'b1;
    start = 1'b0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
